// File: rtl/timer_min_hour_cnt.sv
// Minute/hour BCD timekeeping stage: counts seconds-wrap strobes, applies
// min/hour adjust modes from a synchronized, edge-detected adjust input.
module timer_min_hour_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       min,
    input  logic       hour,
    input  logic       sec_carry,
    input  logic       adj_in,
    output logic [2:0] min_tens,
    output logic [3:0] min_ones,
    output logic [1:0] hour_tens,
    output logic [3:0] hour_ones,
    output logic       min_wrap,
    output logic       day_wrap
);

    typedef enum logic [1:0] {
        MODE_RUN,
        MODE_MIN_ADJ,
        MODE_HOUR_ADJ
    } mode_t;

    mode_t      mode;
    logic       s1, s2, s3;
    logic       adj_pulse;
    logic       min_at_max, hour_at_max;
    logic       min_inc, hour_inc;
    logic       min_wrap_nxt, day_wrap_nxt;
    logic [2:0] min_tens_nxt;
    logic [3:0] min_ones_nxt;
    logic [1:0] hour_tens_nxt;
    logic [3:0] hour_ones_nxt;

    assign adj_pulse   = s2 & ~s3;
    assign min_at_max  = (min_tens == 3'd5) && (min_ones == 4'd9);
    assign hour_at_max = (hour_tens == 2'd2) && (hour_ones == 4'd3);

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        mode         = MODE_RUN;
        min_inc      = 1'b0;
        hour_inc     = 1'b0;
        min_wrap_nxt = 1'b0;
        day_wrap_nxt = 1'b0;
        if (min)       mode = MODE_MIN_ADJ;
        else if (hour) mode = MODE_HOUR_ADJ;

        unique case (mode)
            MODE_MIN_ADJ:  min_inc = adj_pulse;
            MODE_HOUR_ADJ: begin
                min_inc  = sec_carry;
                hour_inc = adj_pulse;
            end
            default: begin
                min_inc      = sec_carry;
                hour_inc     = sec_carry & min_at_max;
                min_wrap_nxt = sec_carry & min_at_max;
                day_wrap_nxt = sec_carry & min_at_max & hour_at_max;
            end
        endcase
    end

    always_comb begin
        min_tens_nxt  = min_tens;
        min_ones_nxt  = min_ones;
        hour_tens_nxt = hour_tens;
        hour_ones_nxt = hour_ones;
        if (min_inc) begin
            if (min_ones == 4'd9) begin
                min_ones_nxt = 4'd0;
                min_tens_nxt = (min_tens == 3'd5) ? 3'd0 : min_tens + 3'd1;
            end else begin
                min_ones_nxt = min_ones + 4'd1;
            end
        end
        if (hour_inc) begin
            if (hour_at_max) begin
                hour_tens_nxt = 2'd0;
                hour_ones_nxt = 4'd0;
            end else if (hour_ones == 4'd9) begin
                hour_tens_nxt = hour_tens + 2'd1;
                hour_ones_nxt = 4'd0;
            end else begin
                hour_ones_nxt = hour_ones + 4'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            min_tens  <= '0;
            min_ones  <= '0;
            hour_tens <= '0;
            hour_ones <= '0;
            min_wrap  <= 1'b0;
            day_wrap  <= 1'b0;
        end else begin
            // s1/s2 resolve metastability on the asynchronous adjust input; s3 is the edge reference.
            s1        <= adj_in;
            s2        <= s1;
            s3        <= s2;
            min_tens  <= min_tens_nxt;
            min_ones  <= min_ones_nxt;
            hour_tens <= hour_tens_nxt;
            hour_ones <= hour_ones_nxt;
            min_wrap  <= min_wrap_nxt;
            day_wrap  <= day_wrap_nxt;
        end
    end

endmodule

// File: tb/tb_timer_min_hour_cnt.sv
// Directed bench for timer_min_hour_cnt: time shown as hhmm decimal, checked
// #1 after each rising edge against hand-computed values.
module tb_timer_min_hour_cnt;

    logic       clk = 1'b0;
    logic       rst, min, hour, sec_carry, adj_in;
    logic [2:0] min_tens;
    logic [3:0] min_ones;
    logic [1:0] hour_tens;
    logic [3:0] hour_ones;
    logic       min_wrap, day_wrap;

    int total = 0;
    int bad   = 0;

    timer_min_hour_cnt dut (
        .clk       (clk),
        .rst       (rst),
        .min       (min),
        .hour      (hour),
        .sec_carry (sec_carry),
        .adj_in    (adj_in),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .hour_tens (hour_tens),
        .hour_ones (hour_ones),
        .min_wrap  (min_wrap),
        .day_wrap  (day_wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int hhmm();
        return int'(hour_tens) * 1000 + int'(hour_ones) * 100 + int'(min_tens) * 10 + int'(min_ones);
    endfunction

    task automatic check(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag, input int t, input int mw, input int dw);
        check({tag, "_time"}, hhmm(), t);
        check({tag, "_min_wrap"}, int'(min_wrap), mw);
        check({tag, "_day_wrap"}, int'(day_wrap), dw);
    endtask

    task automatic pulse_sec(input int n);
        sec_carry = 1'b1;
        repeat (n) tick();
        sec_carry = 1'b0;
    endtask

    // One adj_in rising edge; optionally sec_carry in the same cycle the pulse is seen.
    task automatic adj_edge(input bit with_sec);
        adj_in = 1'b1;
        tick();
        tick();
        sec_carry = with_sec;
        tick();
        sec_carry = 1'b0;
        adj_in    = 1'b0;
    endtask

    task automatic settle_adj();
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b1; min = 1'b0; hour = 1'b0; sec_carry = 1'b0; adj_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_all("reset", 0, 0, 0);

        // Reset mid-count, with a concurrent sec_carry that must be overridden
        pulse_sec(754);
        check("reach_1234", hhmm(), 1234);
        rst = 1'b1; sec_carry = 1'b1;
        tick();
        rst = 1'b0; sec_carry = 1'b0;
        check_all("mid_reset", 0, 0, 0);

        // Normal carry chain
        pulse_sec(1438);
        check_all("preset_2358", 2358, 0, 0);
        pulse_sec(1);
        check_all("run_2359", 2359, 0, 0);
        pulse_sec(1);
        check_all("day_wrap", 0, 1, 1);
        tick();
        check_all("wrap_one_cycle", 0, 0, 0);

        // MIN_ADJ with sec_carry coincident with each adj pulse
        pulse_sec(658);
        check("preset_1058", hhmm(), 1058);
        min = 1'b1;
        adj_edge(1'b1);
        check_all("minadj_1059", 1059, 0, 0);
        settle_adj();
        adj_edge(1'b1);
        check_all("minadj_1000", 1000, 0, 0);
        settle_adj();
        adj_edge(1'b1);
        check_all("minadj_1001", 1001, 0, 0);
        settle_adj();
        pulse_sec(5);
        check("minadj_sec_ignored", hhmm(), 1001);
        min = 1'b0;

        // HOUR_ADJ
        pulse_sec(778);
        check("preset_2259", hhmm(), 2259);
        hour = 1'b1;
        pulse_sec(1);
        check_all("houradj_carry", 2200, 0, 0);
        adj_edge(1'b0);
        check_all("houradj_2300", 2300, 0, 0);
        settle_adj();
        adj_edge(1'b0);
        check_all("houradj_0000", 0, 0, 0);
        settle_adj();
        adj_edge(1'b1);
        check_all("houradj_simul", 101, 0, 0);
        settle_adj();
        hour = 1'b0;

        // Priority and edge detect: adj_in held high for 20 cycles
        pulse_sec(246);
        check("preset_0507", hhmm(), 507);
        min = 1'b1; hour = 1'b1;
        adj_in = 1'b1;
        tick();
        tick();
        check("prio_latency_hold", hhmm(), 507);
        tick();
        check("prio_one_inc", hhmm(), 508);
        repeat (17) tick();
        check_all("prio_held_high", 508, 0, 0);
        adj_in = 1'b0;
        settle_adj();
        min = 1'b0; hour = 1'b0;
        tick();
        check("mode_switch_no_inc", hhmm(), 508);

        // Simultaneous adj_pulse and sec_carry in RUN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_to_0000", hhmm(), 0);
        adj_edge(1'b1);
        check_all("run_simul", 1, 0, 0);
        settle_adj();
        adj_edge(1'b0);
        check("run_adj_ignored", hhmm(), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
